// File: rtl/internet_slot_scheduler.sv
// internet_slot_scheduler: round-robin time-slot arbiter driving the Enable/Sel
// inputs of the 4-way internet demux (Lib, FD, Ribs, School).
// Optional build macro INTERNET_URGENT_EN adds the 'urgent' input; at each
// arbitration point the scan is restricted to urgent requesters when any exist.
//
// state  | meaning
// IDLE   | channel unused, waiting for any request
// GRANT  | slot active, Enable high for the winner
// GAP    | single guard cycle between slots, slot_end pulses

module internet_slot_scheduler #(
    parameter int unsigned SLOT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
`ifdef INTERNET_URGENT_EN
    input  logic [3:0] urgent,
`endif
    output logic       Enable,
    output logic [1:0] Sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       slot_end
);

    localparam logic [7:0] SLOT_LAST = 8'(SLOT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] rr_q, rr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] grant_q, grant_d;
    logic       en_q, en_d;
    logic       busy_q, busy_d;
    logic       end_q, end_d;

    logic [3:0] pool;
    logic [1:0] arb_idx;

    // Candidate set for arbitration: urgent requesters win the scan when present
    always_comb begin
        pool = req;
`ifdef INTERNET_URGENT_EN
        if ((req & urgent) != 4'b0000) begin
            pool = req & urgent;
        end
`endif
    end

    // Round-robin scan starting at rr_q; descending loop so the nearest index wins
    always_comb begin
        logic [1:0] idx;
        arb_idx = rr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_q + 2'(k);
            if (pool[idx]) begin
                arb_idx = idx;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from the next state
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (req != 4'b0000) begin
                    state_d = ST_GRANT;
                    sel_d   = arb_idx;
                    rr_d    = arb_idx + 2'd1;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // Counter stops at SLOT_LAST so it never wraps, even at 255
                if (!req[sel_q] || (cnt_q == SLOT_LAST)) begin
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        en_d    = (state_d == ST_GRANT);
        grant_d = en_d ? (4'b0001 << sel_d) : 4'b0000;
        busy_d  = (state_d != ST_IDLE);
        end_d   = (state_d == ST_GAP);
    end

    // State, pointer, counter and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_q    <= 2'd0;
            cnt_q   <= 8'd0;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            end_q   <= end_d;
        end
    end

    assign Enable   = en_q;
    assign Sel      = sel_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign slot_end = end_q;

endmodule

// File: tb/tb_internet_slot_scheduler.sv
// Bench for internet_slot_scheduler: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.

module tb_internet_slot_scheduler;

    localparam int SLOT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] urgent = 4'b0000;
    logic       Enable;
    logic [1:0] Sel;
    logic [3:0] grant;
    logic       busy;
    logic       slot_end;

    int checks = 0;
    int errors = 0;

    internet_slot_scheduler #(.SLOT_CYCLES(SLOT)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
`ifdef INTERNET_URGENT_EN
        .urgent   (urgent),
`endif
        .Enable   (Enable),
        .Sel      (Sel),
        .grant    (grant),
        .busy     (busy),
        .slot_end (slot_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0=idle, 1=slot active, 2=guard gap
    int m_phase = 0;
    int m_owner = 0;
    int m_used  = 0;
    int m_next  = 0;

    function automatic int pick(input logic [3:0] r, input logic [3:0] u, input int start);
        logic [3:0] cand;
        cand = ((r & u) != 4'b0000) ? (r & u) : r;
        for (int k = 0; k < 4; k++) begin
            if (cand[(start + k) % 4]) return (start + k) % 4;
        end
        return start;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [3:0] u;
`ifdef INTERNET_URGENT_EN
        u = urgent;
`else
        u = 4'b0000;
`endif
        if (reset) begin
            m_phase = 0; m_owner = 0; m_used = 0; m_next = 0;
        end else if (m_phase == 1) begin
            if (!req[m_owner] || m_used == SLOT) m_phase = 2;
            else m_used++;
        end else if (req != 4'b0000) begin
            m_owner = pick(req, u, m_next);
            m_next  = (m_owner + 1) % 4;
            m_used  = 1;
            m_phase = 1;
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        check("Enable",   int'(Enable),   (m_phase == 1) ? 1 : 0);
        check("Sel",      int'(Sel),      m_owner);
        check("grant",    int'(grant),    (m_phase == 1) ? (1 << m_owner) : 0);
        check("busy",     int'(busy),     (m_phase != 0) ? 1 : 0);
        check("slot_end", int'(slot_end), (m_phase == 2) ? 1 : 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] r);
        reset = 1'b1;
        req   = r;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        req = 4'b1111;
        repeat (3) tick();
        check("rst_enable",   int'(Enable),   0);
        check("rst_grant",    int'(grant),    0);
        check("rst_sel",      int'(Sel),      0);
        check("rst_busy",     int'(busy),     0);
        check("rst_slot_end", int'(slot_end), 0);
        reset = 1'b0;

        // All four requesting: 4-cycle slots rotating 0,1,2,3,0 with a gap between
        for (int c = 1; c <= 25; c++) begin
            tick();
            check("rr_enable", int'(Enable), ((c - 1) % 5 != 4) ? 1 : 0);
            if ((c - 1) % 5 != 4) check("rr_sel", int'(Sel), ((c - 1) / 5) % 4);
            else check("rr_slot_end", int'(slot_end), 1);
        end

        // Single requester FD: 4 on, 1 off, repeating
        apply_reset(4'b0010);
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("single_enable",   int'(Enable),   ((c - 1) % 5 != 4) ? 1 : 0);
            check("single_slot_end", int'(slot_end), ((c - 1) % 5 == 4) ? 1 : 0);
            check("single_sel",      int'(Sel),      1);
        end

        // Early release in the second slot cycle
        apply_reset(4'b0010);
        tick();
        check("early_en1", int'(Enable), 1);
        tick();
        check("early_en2", int'(Enable), 1);
        check("early_grant2", int'(grant), 2);
        req = 4'b0000;
        tick();
        check("early_gap_en",  int'(Enable),   0);
        check("early_gap_end", int'(slot_end), 1);
        check("early_gap_busy", int'(busy),    1);
        check("early_gap_sel", int'(Sel),      1);
        tick();
        check("early_idle_busy", int'(busy),     0);
        check("early_idle_end",  int'(slot_end), 0);

        // Asynchronous reset during a School slot
        apply_reset(4'b1000);
        tick();
        check("school_sel", int'(Sel), 3);
        check("school_en",  int'(Enable), 1);
        #3 reset = 1'b1;
        #1;
        check("midrst_en",    int'(Enable), 0);
        check("midrst_grant", int'(grant),  0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_sel",   int'(Sel),   3);
        check("post_rst_grant", int'(grant), 8);
        req = 4'b1001;
        repeat (4) tick();
        check("post_rst_gap", int'(slot_end), 1);
        tick();
        check("post_rst_lib", int'(Sel), 0);

`ifdef INTERNET_URGENT_EN
        urgent = 4'b0100;
        apply_reset(4'b1111);
        tick();
        check("urg_ribs", int'(Sel), 2);
        urgent = 4'b0000;
        repeat (5) tick();
        check("urg_school", int'(Sel), 3);
        check("urg_school_en", int'(Enable), 1);
        repeat (5) tick();
        check("urg_lib", int'(Sel), 0);
`endif

        // Randomized traffic, with occasional asynchronous resets
        apply_reset(4'b0000);
        for (int n = 0; n < 3000; n++) begin
            tick();
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 5) == 0) urgent = 4'($urandom);
            if ($urandom_range(0, 249) == 0) begin
                reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/internet_slot_scheduler.md
Name: internet_slot_scheduler

Overview:
- Time-slot scheduler that shares the single 4-bit internet channel among four destinations: Lib, FD, Ribs and School.
- It drives the Enable and Sel inputs of the 4-way internet demux from per-destination requests.
- Arbitration is round-robin, with a bounded slot length and a one-cycle guard gap between slots.
- It sits directly upstream of the demux; the demux data path is untouched.

Parameters:
- SLOT_CYCLES, 4: maximum cycles a destination holds the channel per grant. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  per-destination request, indexed by Sel code: [0]=Lib (Sel 00), [1]=FD (Sel 01), [2]=Ribs (Sel 10), [3]=School (Sel 11).
- Enable  output  1  demux enable. High only while a slot is active.
- Sel  output  2  demux select, equal to the granted index.
- grant  output  4  one-hot grant. Equals 1<<Sel when Enable=1, else 0.
- busy  output  1  high in GRANT and GAP states.
- slot_end  output  1  one-cycle pulse in the first GAP cycle after any slot.

Behaviour:
- Reset (async assert, sync-safe deassert), all registered:
  - state=IDLE, Enable=0, Sel=00, grant=0000, busy=0, slot_end=0.
  - rr_ptr=0, slot counter=0.
- All outputs are registered. No combinational path from req to any output.
- States:
  - IDLE: Enable=0.
    - If req!=0, the arbiter picks a winner; next state is GRANT.
    - Otherwise stay in IDLE.
  - GRANT: Enable=1, Sel=winner, grant=one-hot(winner), busy=1.
    - The slot counter is 1 in the first GRANT cycle and increments each cycle.
    - Leave to GAP when req[winner]=0 is sampled, or when counter==SLOT_CYCLES, whichever comes first.
    - Requests from other indices never preempt an active slot.
  - GAP: exactly one cycle. Enable=0, grant=0, Sel holds its last value, busy=1, slot_end=1.
    - If req!=0, arbitrate and go to GRANT; otherwise go to IDLE.
- Arbitration (IDLE->GRANT and GAP->GRANT only):
  - Scan req starting at index rr_ptr, ascending, mod 4; the first set bit wins.
  - On grant to index i, rr_ptr <= (i+1) mod 4.
- Latency: a req rising before edge n gives Enable=1 after edge n (1 cycle) when in IDLE.
- Slot counter width is 8 bits. It must not wrap: SLOT_CYCLES=255 ends the slot at count 255.
- SLOT_CYCLES=1 gives single-cycle slots with a GAP between every slot.
- A winner whose req drops during GRANT exits at the next edge. It still consumed at least one Enable cycle.
- A req already low at the first GRANT edge ends the slot after one cycle.
- If all requests drop at the same time, GRANT->GAP->IDLE.
- Asserting reset mid-slot immediately forces Enable=0 and grant=0 (asynchronous), and rr_ptr returns to 0.
- Enable=1 and grant!=0 never occur in the GAP or IDLE states. grant is never multi-hot.

Optional Feature:
- Macro: INTERNET_URGENT_EN
- With the macro defined:
  - Adds port `urgent  input  4`, indexed like req.
  - At each arbitration point, if (req & urgent)!=0, the round-robin scan runs over req & urgent only. Otherwise it runs over req.
  - rr_ptr updates identically in both cases.
  - urgent has no effect during GRANT; there is no preemption.
- Without the macro: the port is absent and arbitration uses req only.

Test Plan:
- Reset: hold reset=1 with req=1111, then release.
  - Expect Enable=0, grant=0000, Sel=00 while reset is high.
  - The first grant after release goes to Lib (Sel 00).
- Single requester: req=0010 held, SLOT_CYCLES=4.
  - Expect Enable=1, Sel=01 for 4 cycles, then 1 GAP cycle with Enable=0 and slot_end=1, then FD again.
  - The pattern repeats 4-on/1-off.
- Round-robin fairness: req=1111 held from reset.
  - Expect grant sequence Sel 00, 01, 10, 11, 00, each lasting 4 cycles with a 1-cycle gap between slots.
- Early release: FD granted, req[1] dropped at GRANT cycle 2.
  - Expect Enable to fall after that edge, one GAP cycle, then IDLE if req=0.
- Mid-slot reset: reset asserted during a School slot.
  - Expect Enable=0 and grant=0000 asynchronously.
  - After release with req=1000, expect School granted, with rr_ptr starting from 0.
- INTERNET_URGENT_EN: req=1111, urgent=0100, rr_ptr=0.
  - Expect Ribs (Sel 10) granted first.
  - With urgent=0000 next, expect School (Sel 11), then Lib.
